// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared definitions for the RV32I branch prediction slice:
//                BHT reset value, controller FSM encoding and the 2-bit
//                saturating counter update.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   // Weak not-taken: one taken resolve is enough to flip the prediction.
   localparam logic [1:0] BHT_INIT = 2'b01;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } br_state_t;

   // Saturating 2-bit direction counter step.
   function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      nxt = cur;
      if (taken && cur != 2'b11) begin
         nxt = cur + 2'b01;
      end else if (!taken && cur != 2'b00) begin
         nxt = cur - 2'b01;
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl_if
//  Description : Pipeline-facing bundle of the branch controller: IF-stage
//                predict port, EX-stage resolve port, redirect/flush and
//                statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_ctrl_if #(
   parameter int XLEN = 32
);
   // IF stage predict port
   logic            if_valid_i;
   logic [XLEN-1:0] if_pc_i;
   logic            pred_taken_o;
   logic [XLEN-1:0] pred_target_o;

   // EX stage resolve port
   logic            ex_valid_i;
   logic            ex_branch_i;
   logic            ex_taken_i;
   logic [XLEN-1:0] ex_pc_i;
   logic [XLEN-1:0] ex_target_i;
   logic            ex_pred_taken_i;
   logic [XLEN-1:0] ex_pred_target_i;

   // Recovery and statistics
   logic            redirect_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            flush_o;
   logic            busy_o;
   logic [31:0]     br_count_o;
   logic [31:0]     mis_count_o;

   // Controller side
   modport slave (
      input  if_valid_i, if_pc_i,
      output pred_taken_o, pred_target_o,
      input  ex_valid_i, ex_branch_i, ex_taken_i, ex_pc_i, ex_target_i,
      input  ex_pred_taken_i, ex_pred_target_i,
      output redirect_o, redirect_pc_o, flush_o, busy_o, br_count_o, mis_count_o
   );

   // Pipeline side
   modport master (
      output if_valid_i, if_pc_i,
      input  pred_taken_o, pred_target_o,
      output ex_valid_i, ex_branch_i, ex_taken_i, ex_pc_i, ex_target_i,
      output ex_pred_taken_i, ex_pred_target_i,
      input  redirect_o, redirect_pc_o, flush_o, busy_o, br_count_o, mis_count_o
   );

endinterface
`default_nettype wire

// File: rtl/branch_pred_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_table
//  Description : Direct-mapped BHT (2-bit counters) + BTB (valid/tag/target).
//                One combinational read port for IF, one synchronous write
//                port for training. Reads never see a same-cycle write.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_table
   import riscv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int IDX_BITS = 6
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   // read port
   input  wire logic [XLEN-1:0] rd_pc,
   output logic                 rd_hit,
   output logic                 rd_dir,
   output logic [XLEN-1:0]      rd_target,
   // write port
   input  wire logic            wr_en,
   input  wire logic [XLEN-1:0] wr_pc,
   input  wire logic            wr_taken,
   input  wire logic [XLEN-1:0] wr_target
);

   localparam int c_entries = 2 ** IDX_BITS;
   localparam int c_tag_w   = XLEN - IDX_BITS - 2;

   logic [1:0]         r_bht        [c_entries];
   logic [c_entries-1:0] r_btb_valid;
   logic [c_tag_w-1:0] r_btb_tag    [c_entries];
   logic [XLEN-1:0]    r_btb_target [c_entries];

   logic [IDX_BITS-1:0] w_rd_idx;
   logic [IDX_BITS-1:0] w_wr_idx;
   logic [c_tag_w-1:0]  w_rd_tag;
   logic [c_tag_w-1:0]  w_wr_tag;

   // Instructions are word aligned, the low PC bits carry no information.
   logic w_unused_pc_lsbs;
   assign w_unused_pc_lsbs = ^{rd_pc[1:0], wr_pc[1:0]};

   assign w_rd_idx = rd_pc[IDX_BITS+1:2];
   assign w_wr_idx = wr_pc[IDX_BITS+1:2];
   assign w_rd_tag = rd_pc[XLEN-1:IDX_BITS+2];
   assign w_wr_tag = wr_pc[XLEN-1:IDX_BITS+2];

   // Combinational lookup: target is presented even on a miss.
   always_comb begin
      rd_hit    = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
      rd_dir    = r_bht[w_rd_idx][1];
      rd_target = r_btb_target[w_rd_idx];
   end

   // Direction counters and BTB valid bits: reset-initialised state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_entries; i++) begin
            r_bht[i] <= BHT_INIT;
         end
         r_btb_valid <= '0;
      end else if (wr_en) begin
         r_bht[w_wr_idx] <= bht_next(r_bht[w_wr_idx], wr_taken);
         if (wr_taken) begin
            r_btb_valid[w_wr_idx] <= 1'b1;
         end
      end
   end

   // Tag/target payload is gated by the valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      if (wr_en && wr_taken) begin
         r_btb_tag[w_wr_idx]    <= w_wr_tag;
         r_btb_target[w_wr_idx] <= wr_target;
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : Branch prediction and resolution controller for the 5-stage
//                RV32I pipeline. Predicts in IF, resolves and trains from EX,
//                and sequences redirect + IF/ID, ID/EX flush on mispredict.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl
   import riscv_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int IDX_BITS     = 6,
   parameter int FLUSH_CYCLES = 2
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   branch_ctrl_if.slave  bus
);

   localparam logic [2:0] c_cnt_init = 3'(FLUSH_CYCLES - 1);

   br_state_t       r_state;
   logic [2:0]      r_cnt;
   logic            r_redirect;
   logic [XLEN-1:0] r_redirect_pc;
   logic            r_flush;
   logic            r_busy;
   logic [31:0]     r_br_count;
   logic [31:0]     r_mis_count;

   logic            r_trn_valid;
   logic [XLEN-1:0] r_trn_pc;
   logic            r_trn_taken;
   logic [XLEN-1:0] r_trn_target;

   logic            w_rd_hit;
   logic            w_rd_dir;
   logic [XLEN-1:0] w_rd_target;
   logic            w_res;
   logic            w_mis;
   logic [XLEN-1:0] w_correct_pc;

   branch_pred_table #(
      .XLEN     (XLEN),
      .IDX_BITS (IDX_BITS)
   ) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_pc     (bus.if_pc_i),
      .rd_hit    (w_rd_hit),
      .rd_dir    (w_rd_dir),
      .rd_target (w_rd_target),
      .wr_en     (r_trn_valid),
      .wr_pc     (r_trn_pc),
      .wr_taken  (r_trn_taken),
      .wr_target (r_trn_target)
   );

   assign bus.pred_taken_o  = bus.if_valid_i & w_rd_hit & w_rd_dir;
   assign bus.pred_target_o = w_rd_target;

   // Resolve/mispredict decode; EX contents are already squashed while flushing.
   always_comb begin
      w_res = bus.ex_valid_i & bus.ex_branch_i & (r_state == IDLE);
      w_mis = w_res & ((bus.ex_taken_i != bus.ex_pred_taken_i) |
                       (bus.ex_taken_i & (bus.ex_target_i != bus.ex_pred_target_i)));
      w_correct_pc = bus.ex_taken_i ? bus.ex_target_i : (bus.ex_pc_i + XLEN'(4));
   end

   // Training register: table write lands one cycle after the resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trn_valid  <= 1'b0;
         r_trn_pc     <= '0;
         r_trn_taken  <= 1'b0;
         r_trn_target <= '0;
      end else begin
         r_trn_valid <= w_res;
         if (w_res) begin
            r_trn_pc     <= bus.ex_pc_i;
            r_trn_taken  <= bus.ex_taken_i;
            r_trn_target <= bus.ex_target_i;
         end
      end
   end

   // Recovery FSM with registered redirect/flush/busy and statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_flush       <= 1'b0;
         r_busy        <= 1'b0;
         r_br_count    <= '0;
         r_mis_count   <= '0;
      end else begin
         r_redirect <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_res) begin
                  r_br_count <= r_br_count + 32'd1;
               end
               if (w_mis) begin
                  r_mis_count   <= r_mis_count + 32'd1;
                  r_state       <= FLUSH;
                  r_cnt         <= c_cnt_init;
                  r_redirect    <= 1'b1;
                  r_redirect_pc <= w_correct_pc;
                  r_flush       <= 1'b1;
                  r_busy        <= 1'b1;
               end
            end
            FLUSH: begin
               if (r_cnt == 3'd0) begin
                  r_state <= IDLE;
                  r_flush <= 1'b0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_flush <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.redirect_o    = r_redirect;
   assign bus.redirect_pc_o = r_redirect_pc;
   assign bus.flush_o       = r_flush;
   assign bus.busy_o        = r_busy;
   assign bus.br_count_o    = r_br_count;
   assign bus.mis_count_o   = r_mis_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_ctrl
//  Description : Directed self-checking bench for branch_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   branch_ctrl_if #(.XLEN(32)) bus ();

   branch_ctrl #(
      .XLEN         (32),
      .IDX_BITS     (6),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one EX instruction for a single cycle; returns 1 time unit after the edge.
   task automatic ex_issue(input logic br, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
      @(negedge clk);
      bus.ex_valid_i       = 1'b1;
      bus.ex_branch_i      = br;
      bus.ex_pc_i          = pc;
      bus.ex_taken_i       = taken;
      bus.ex_target_i      = tgt;
      bus.ex_pred_taken_i  = ptaken;
      bus.ex_pred_target_i = ptgt;
      @(posedge clk);
      #1;
      bus.ex_valid_i  = 1'b0;
      bus.ex_branch_i = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(2);
      n_checks++; if (bus.busy_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: busy=%b flush=%b redirect=%b, required 0/0/0", bus.busy_o, bus.flush_o, bus.redirect_o); end
      n_checks++; if (bus.redirect_pc_o !== 32'h0 || bus.br_count_o !== 32'h0 || bus.mis_count_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_regs: rpc=%h br=%0d mis=%0d, required 0/0/0", bus.redirect_pc_o, bus.br_count_o, bus.mis_count_o); end
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_first_mispredict;
      bus.if_valid_i = 1'b1;
      bus.if_pc_i    = 32'h100;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b0) begin
         n_fail++; $display("FAIL cold_predict: pred_taken=%b, required 0", bus.pred_taken_o); end
      ex_issue(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
      n_checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h140) begin
         n_fail++; $display("FAIL mis1_redirect: redirect=%b pc=%h, required 1/00000140", bus.redirect_o, bus.redirect_pc_o); end
      n_checks++; if (bus.flush_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.mis_count_o !== 32'd1 || bus.br_count_o !== 32'd1) begin
         n_fail++; $display("FAIL mis1_state: flush=%b busy=%b mis=%0d br=%0d, required 1/1/1/1", bus.flush_o, bus.busy_o, bus.mis_count_o, bus.br_count_o); end
      step(1);
      n_checks++; if (bus.redirect_o !== 1'b0 || bus.flush_o !== 1'b1) begin
         n_fail++; $display("FAIL mis1_cycle2: redirect=%b flush=%b, required 0/1", bus.redirect_o, bus.flush_o); end
      step(1);
      n_checks++; if (bus.flush_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL mis1_end: flush=%b busy=%b, required 0/0", bus.flush_o, bus.busy_o); end
   endtask

   task automatic test_train_taken;
      bus.if_pc_i = 32'h100;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b1) begin
         n_fail++; $display("FAIL trained_once: pred_taken=%b, required 1", bus.pred_taken_o); end
      for (int i = 0; i < 2; i++) begin
         ex_issue(1'b1, 32'h100, 1'b1, 32'h140, 1'b1, 32'h140);
         n_checks++; if (bus.redirect_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL correct_resolve%0d: redirect=%b busy=%b, required 0/0", i, bus.redirect_o, bus.busy_o); end
      end
      step(1);
      n_checks++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h140) begin
         n_fail++; $display("FAIL strong_predict: taken=%b target=%h, required 1/00000140", bus.pred_taken_o, bus.pred_target_o); end
      n_checks++; if (bus.br_count_o !== 32'd3 || bus.mis_count_o !== 32'd1) begin
         n_fail++; $display("FAIL counts_t2: br=%0d mis=%0d, required 3/1", bus.br_count_o, bus.mis_count_o); end
   endtask

   task automatic test_not_taken_mispredict;
      ex_issue(1'b1, 32'h100, 1'b0, 32'h140, 1'b1, 32'h140);
      n_checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h104 || bus.mis_count_o !== 32'd2) begin
         n_fail++; $display("FAIL nt_redirect: redirect=%b pc=%h mis=%0d, required 1/00000104/2", bus.redirect_o, bus.redirect_pc_o, bus.mis_count_o); end
      step(2);
      // counter 3 -> 2: still predicts taken
      n_checks++; if (bus.pred_taken_o !== 1'b1) begin
         n_fail++; $display("FAIL bht_decrement: pred_taken=%b, required 1", bus.pred_taken_o); end
   endtask

   task automatic test_resolve_in_flush;
      ex_issue(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
      ex_issue(1'b1, 32'h100, 1'b0, 32'h140, 1'b1, 32'h140);
      n_checks++; if (bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h140) begin
         n_fail++; $display("FAIL flush_ignore_redirect: redirect=%b pc=%h, required 0/00000140", bus.redirect_o, bus.redirect_pc_o); end
      n_checks++; if (bus.br_count_o !== 32'd5 || bus.mis_count_o !== 32'd3) begin
         n_fail++; $display("FAIL flush_ignore_counts: br=%0d mis=%0d, required 5/3", bus.br_count_o, bus.mis_count_o); end
      step(2);
      n_checks++; if (bus.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_ignore_end: busy=%b, required 0", bus.busy_o); end
   endtask

   task automatic test_aliasing;
      bus.if_pc_i = 32'h200;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h140) begin
         n_fail++; $display("FAIL alias: taken=%b target=%h, required 0/00000140", bus.pred_taken_o, bus.pred_target_o); end
      bus.if_pc_i    = 32'h100;
      bus.if_valid_i = 1'b0;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b0) begin
         n_fail++; $display("FAIL if_invalid: pred_taken=%b, required 0", bus.pred_taken_o); end
      bus.if_valid_i = 1'b1;
   endtask

   task automatic test_non_branch;
      ex_issue(1'b0, 32'h100, 1'b1, 32'h180, 1'b0, 32'h0);
      n_checks++; if (bus.redirect_o !== 1'b0 || bus.br_count_o !== 32'd5 || bus.mis_count_o !== 32'd3) begin
         n_fail++; $display("FAIL non_branch: redirect=%b br=%0d mis=%0d, required 0/5/3", bus.redirect_o, bus.br_count_o, bus.mis_count_o); end
   endtask

   task automatic test_reset_mid_flush;
      ex_issue(1'b1, 32'h300, 1'b1, 32'h380, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.flush_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h0) begin
         n_fail++; $display("FAIL async_reset: flush=%b busy=%b redirect=%b pc=%h, required 0/0/0/0", bus.flush_o, bus.busy_o, bus.redirect_o, bus.redirect_pc_o); end
      n_checks++; if (bus.br_count_o !== 32'd0 || bus.mis_count_o !== 32'd0) begin
         n_fail++; $display("FAIL async_reset_counts: br=%0d mis=%0d, required 0/0", bus.br_count_o, bus.mis_count_o); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      bus.if_pc_i = 32'h100;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b0) begin
         n_fail++; $display("FAIL btb_cleared: pred_taken=%b, required 0", bus.pred_taken_o); end
      bus.if_pc_i = 32'h300;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b0) begin
         n_fail++; $display("FAIL dropped_train: pred_taken=%b, required 0", bus.pred_taken_o); end
      // one taken resolve from BHT_INIT (01) must reach 10 and predict taken
      ex_issue(1'b1, 32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
      step(2);
      bus.if_pc_i = 32'h100;
      #1;
      n_checks++; if (bus.pred_taken_o !== 1'b1) begin
         n_fail++; $display("FAIL bht_init: pred_taken=%b, required 1", bus.pred_taken_o); end
   endtask

   task automatic test_pc_wrap;
      ex_issue(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
      n_checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h0 || bus.mis_count_o !== 32'd2) begin
         n_fail++; $display("FAIL pc_wrap: redirect=%b pc=%h mis=%0d, required 1/00000000/2", bus.redirect_o, bus.redirect_pc_o, bus.mis_count_o); end
      step(2);
   endtask

   initial begin
      n_checks             = 0;
      n_fail               = 0;
      rst_n                = 1'b0;
      bus.if_valid_i       = 1'b0;
      bus.if_pc_i          = 32'h0;
      bus.ex_valid_i       = 1'b0;
      bus.ex_branch_i      = 1'b0;
      bus.ex_taken_i       = 1'b0;
      bus.ex_pc_i          = 32'h0;
      bus.ex_target_i      = 32'h0;
      bus.ex_pred_taken_i  = 1'b0;
      bus.ex_pred_target_i = 32'h0;

      test_reset();
      test_first_mispredict();
      test_train_taken();
      test_not_taken_mispredict();
      test_resolve_in_flush();
      test_aliasing();
      test_non_branch();
      test_reset_mid_flush();
      test_pc_wrap();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
